core_to_bank_router: RTL and testbench

CORE_TO_BANK_ROUTER -- requirements
Module: core_to_bank_router

---
 rtl/core_to_bank_router.sv | 173 +++++++++++++++++
 tb/tb_core_to_bank_router.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/core_to_bank_router.sv
// core_to_bank_router: routes three instruction-fetch cores onto three
// single-cycle memory banks with per-bank round-robin arbitration.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   core_req[2:0]           per-core fetch request
//   core_addr_0/1/2         per-core fetch address (held while requesting)
//   core_gnt[2:0]           per-core combinational grant
//   core_rvalid[2:0]        per-core response valid (one cycle after grant)
//   core_err[2:0]           per-core illegal-bank error flag
//   core_rdata_0/1/2        per-core response data (0 when not valid)
//   bank_req[2:0]           per-bank read strobe
//   bank_addr_0/1/2         per-bank forwarded address (0 when idle)
//   bank_rdata_0/1/2        per-bank read data, valid one cycle after req

module core_to_bank_router #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BANK_LSB = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        core_req,
    input  logic [ADDR_W-1:0] core_addr_0,
    input  logic [ADDR_W-1:0] core_addr_1,
    input  logic [ADDR_W-1:0] core_addr_2,
    output logic [2:0]        core_gnt,
    output logic [2:0]        core_rvalid,
    output logic [2:0]        core_err,
    output logic [DATA_W-1:0] core_rdata_0,
    output logic [DATA_W-1:0] core_rdata_1,
    output logic [DATA_W-1:0] core_rdata_2,
    output logic [2:0]        bank_req,
    output logic [ADDR_W-1:0] bank_addr_0,
    output logic [ADDR_W-1:0] bank_addr_1,
    output logic [ADDR_W-1:0] bank_addr_2,
    input  logic [DATA_W-1:0] bank_rdata_0,
    input  logic [DATA_W-1:0] bank_rdata_1,
    input  logic [DATA_W-1:0] bank_rdata_2
);

    // (a + k) mod 3 for a, k in {0,1,2}
    function automatic logic [1:0] add_mod3(
        input logic [1:0] a,
        input logic [1:0] k
    );
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

    logic [ADDR_W-1:0] addr  [3];
    logic [DATA_W-1:0] bdata [3];
    logic [DATA_W-1:0] rdata [3];
    logic [1:0]        bidx  [3];

    logic [2:0] req_live;
    logic [2:0] illegal;
    logic [2:0] want   [3];
    logic [2:0] win    [3];
    logic [1:0] win_id [3];
    logic [ADDR_W-1:0] baddr [3];

    logic [1:0] ptr     [3];
    logic [2:0] rsp_vld;
    logic [1:0] rsp_own [3];
    logic [2:0] err_vld;

    assign addr[0]  = core_addr_0;
    assign addr[1]  = core_addr_1;
    assign addr[2]  = core_addr_2;
    assign bdata[0] = bank_rdata_0;
    assign bdata[1] = bank_rdata_1;
    assign bdata[2] = bank_rdata_2;

    // Requests are masked during reset so grants and bank strobes stay low
    // even though they are combinational.
    assign req_live = core_req & {3{rst_n}};

    always_comb begin
        for (int n = 0; n < 3; n++) begin
            bidx[n]    = addr[n][BANK_LSB+1:BANK_LSB];
            illegal[n] = req_live[n] && (bidx[n] == 2'd3);
        end
        for (int b = 0; b < 3; b++) begin
            for (int n = 0; n < 3; n++) begin
                want[b][n] = req_live[n] && (bidx[n] == 2'(b));
            end
        end
    end

    // Per-bank round robin: scan ptr, ptr+1, ptr+2; first requester wins.
    always_comb begin
        for (int b = 0; b < 3; b++) begin
            logic [1:0] idx;
            win[b]    = '0;
            win_id[b] = '0;
            for (int k = 0; k < 3; k++) begin
                idx = add_mod3(ptr[b], 2'(k));
                if ((win[b] == 3'b000) && want[b][idx]) begin
                    win[b][idx] = 1'b1;
                    win_id[b]   = idx;
                end
            end
        end
    end

    always_comb begin
        core_gnt = illegal;
        for (int b = 0; b < 3; b++) begin
            core_gnt    = core_gnt | win[b];
            bank_req[b] = |want[b];
            baddr[b]    = '0;
            if (bank_req[b]) begin
                unique case (win_id[b])
                    2'd0:    baddr[b] = addr[0];
                    2'd1:    baddr[b] = addr[1];
                    default: baddr[b] = addr[2];
                endcase
            end
        end
    end

    assign bank_addr_0 = baddr[0];
    assign bank_addr_1 = baddr[1];
    assign bank_addr_2 = baddr[2];

    // Response bookkeeping: per bank remember who was granted, per core
    // remember an illegal-bank grant. Reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 3; b++) begin
                ptr[b]     <= 2'd0;
                rsp_own[b] <= 2'd0;
            end
            rsp_vld <= '0;
            err_vld <= '0;
        end else begin
            for (int b = 0; b < 3; b++) begin
                rsp_vld[b] <= bank_req[b];
                if (bank_req[b]) begin
                    rsp_own[b] <= win_id[b];
                    ptr[b]     <= add_mod3(win_id[b], 2'd1);
                end
            end
            err_vld <= illegal;
        end
    end

    // A core gets at most one grant per cycle, so at most one bank (or the
    // error path) can claim it in the response cycle.
    always_comb begin
        core_err = err_vld;
        for (int n = 0; n < 3; n++) begin
            core_rvalid[n] = err_vld[n];
            rdata[n]       = '0;
            for (int b = 0; b < 3; b++) begin
                if (rsp_vld[b] && (rsp_own[b] == 2'(n))) begin
                    core_rvalid[n] = 1'b1;
                    rdata[n]       = bdata[b];
                end
            end
        end
    end

    assign core_rdata_0 = rdata[0];
    assign core_rdata_1 = rdata[1];
    assign core_rdata_2 = rdata[2];

endmodule

// File: tb/tb_core_to_bank_router.sv
// Scoreboard bench for core_to_bank_router: directed stimulus pushes
// expected grant and response records; a negedge monitor checks them.

module tb_core_to_bank_router;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct packed {
        int                 cyc;
        logic [2:0]         gnt;
        logic [2:0]         breq;
        logic [2:0][AW-1:0] baddr;
    } gexp_t;

    typedef struct packed {
        int                 cyc;
        logic [2:0]         rv;
        logic [2:0]         err;
        logic [2:0][DW-1:0] data;
    } rexp_t;

    logic          clk;
    logic          rst_n;
    logic [2:0]    core_req;
    logic [AW-1:0] core_addr_0, core_addr_1, core_addr_2;
    logic [2:0]    core_gnt, core_rvalid, core_err;
    logic [DW-1:0] core_rdata_0, core_rdata_1, core_rdata_2;
    logic [2:0]    bank_req;
    logic [AW-1:0] bank_addr_0, bank_addr_1, bank_addr_2;
    logic [DW-1:0] bank_rdata_0, bank_rdata_1, bank_rdata_2;

    gexp_t gnt_q[$];
    rexp_t rsp_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;

    core_to_bank_router #(
        .ADDR_W(AW), .DATA_W(DW), .BANK_LSB(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req),
        .core_addr_0(core_addr_0),
        .core_addr_1(core_addr_1),
        .core_addr_2(core_addr_2),
        .core_gnt(core_gnt),
        .core_rvalid(core_rvalid),
        .core_err(core_err),
        .core_rdata_0(core_rdata_0),
        .core_rdata_1(core_rdata_1),
        .core_rdata_2(core_rdata_2),
        .bank_req(bank_req),
        .bank_addr_0(bank_addr_0),
        .bank_addr_1(bank_addr_1),
        .bank_addr_2(bank_addr_2),
        .bank_rdata_0(bank_rdata_0),
        .bank_rdata_1(bank_rdata_1),
        .bank_rdata_2(bank_rdata_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [DW-1:0] mem_fn(
        input logic [1:0] b, input logic [AW-1:0] a
    );
        return a ^ (32'h1111_1111 * (32'(b) + 32'd1));
    endfunction

    // Bank models: data only meaningful the cycle after a strobe.
    always @(posedge clk) begin
        bank_rdata_0 <= bank_req[0] ? mem_fn(2'd0, bank_addr_0)
                                    : 32'hDEAD_0000;
        bank_rdata_1 <= bank_req[1] ? mem_fn(2'd1, bank_addr_1)
                                    : 32'hDEAD_0001;
        bank_rdata_2 <= bank_req[2] ? mem_fn(2'd2, bank_addr_2)
                                    : 32'hDEAD_0002;
    end

    task automatic chk(
        input string name, input logic [127:0] act, input logic [127:0] exp
    );
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h",
                     name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of requests; eg/eb are the hand-computed grant and
    // bank strobe vectors. rsp=0 means no response may follow.
    task automatic step(
        input logic [2:0]    req,
        input logic [AW-1:0] a0, a1, a2,
        input logic [2:0]    eg,
        input logic [2:0]    eb,
        input bit            rsp
    );
        gexp_t g;
        rexp_t r;
        logic [AW-1:0] a [3];
        logic [1:0] bk;
        @(posedge clk);
        #1;
        core_req    = req;
        core_addr_0 = a0;
        core_addr_1 = a1;
        core_addr_2 = a2;
        a[0] = a0; a[1] = a1; a[2] = a2;
        g.cyc = cyc; g.gnt = eg; g.breq = eb; g.baddr = '0;
        r.cyc = cyc + 1; r.rv = '0; r.err = '0; r.data = '0;
        for (int n = 0; n < 3; n++) begin
            if (eg[n]) begin
                bk = a[n][3:2];
                r.rv[n] = 1'b1;
                if (bk == 2'd3) begin
                    r.err[n] = 1'b1;
                end else begin
                    g.baddr[bk] = a[n];
                    r.data[n]   = mem_fn(bk, a[n]);
                end
            end
        end
        gnt_q.push_back(g);
        if (rsp && eg != 3'b000) rsp_q.push_back(r);
    endtask

    // Monitor: grant-phase and response-phase checks, decoupled from stimulus.
    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
            g = gnt_q.pop_front();
            chk("core_gnt", 128'(core_gnt), 128'(g.gnt));
            chk("bank_req", 128'(bank_req), 128'(g.breq));
            chk("bank_addr",
                128'({bank_addr_2, bank_addr_1, bank_addr_0}),
                128'(g.baddr));
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
            r = rsp_q.pop_front();
        end else begin
            r = '0;
            r.cyc = cyc;
        end
        chk("core_rvalid", 128'(core_rvalid), 128'(r.rv));
        chk("core_err", 128'(core_err), 128'(r.err));
        chk("core_rdata",
            128'({core_rdata_2, core_rdata_1, core_rdata_0}),
            128'(r.data));
    end

    initial begin
        rst_n = 1'b0;
        core_req = '0;
        core_addr_0 = '0; core_addr_1 = '0; core_addr_2 = '0;

        // Reset holds grants/strobes low even with live requests.
        step(3'b111, 32'h0, 32'h10, 32'h20, 3'b000, 3'b000, 0);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single fetch, core 1 -> bank 1.
        step(3'b010, 32'h0, 32'h4, 32'h0, 3'b010, 3'b010, 1);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1);

        // Contention on bank 0: ptr0 walks 0 -> 1 -> 2 -> 0.
        step(3'b111, 32'h0, 32'h10, 32'h20, 3'b001, 3'b001, 1);
        step(3'b111, 32'h0, 32'h10, 32'h20, 3'b010, 3'b001, 1);
        step(3'b111, 32'h0, 32'h10, 32'h20, 3'b100, 3'b001, 1);
        // ptr0 back at 0: core 0 wins again.
        step(3'b011, 32'h30, 32'h10, 32'h0, 3'b001, 3'b001, 1);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1);

        // Parallel: core0->bank2, core1->bank0, core2->bank1.
        step(3'b111, 32'h8, 32'h40, 32'h44, 3'b111, 3'b111, 1);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1);

        // Illegal bank on core 2, then illegal core 0 beside a legal core 1.
        step(3'b100, 32'h0, 32'h0, 32'hC, 3'b100, 3'b000, 1);
        step(3'b011, 32'h1C, 32'h4, 32'h0, 3'b011, 3'b010, 1);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1);

        // Reset mid-transaction: the pending response must vanish.
        step(3'b001, 32'h4, 32'h0, 32'h0, 3'b001, 3'b010, 0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        step(3'b101, 32'h4, 32'h0, 32'h14, 3'b000, 3'b000, 0);
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 0);

        // Fairness on bank 1 from a fresh ptr1=0.
        for (int i = 0; i < 6; i++) begin
            step(3'b101, 32'h4, 32'h0, 32'h14,
                 (i % 2 == 0) ? 3'b001 : 3'b100, 3'b010, 1);
        end
        step(3'b000, 32'h0, 32'h0, 32'h0, 3'b000, 3'b000, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("queues_drained", 128'(gnt_q.size() + rsp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
